// File: rtl/fraction_mult_pkg.sv
// Shared types and helpers for the Q1.(N-1) fraction multiplier.
// Used by fraction_multiplier_param and, under FRACTION_MULT_ROUND_EN, fraction_mult_round.
package fraction_mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit-counter width; N is at least 3, so this is never below 2.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] sat_pos(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fraction_mult_round.sv
// Combinational round-half-up of a Q1.(2N-2) product to Q1.(N-1) with positive saturation.
// Only instantiated when FRACTION_MULT_ROUND_EN is defined.
module fraction_mult_round
  import fraction_mult_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [2*N-2:0] i_product,
  output logic [N-1:0]   o_round,
  output logic           o_ovf_rnd
);

  localparam logic [N-1:0] MaxPos = N'(sat_pos(N));

  logic [N-1:0] w_top;
  logic         w_half;
  logic         w_unused;

  assign w_top  = i_product[2*N-2:N-1];
  assign w_half = i_product[N-2];

  // Adding the half bit can only overflow when the top is already the positive maximum.
  assign o_ovf_rnd = w_half && (w_top == MaxPos);
  assign o_round   = o_ovf_rnd ? MaxPos : (w_top + N'(w_half));

  assign w_unused = ^i_product[N-3:0];

endmodule

// File: rtl/fraction_multiplier_param.sv
// Radix-2 add/shift multiplier for Q1.(N-1) two's-complement fractions with -1 x -1 saturation.
// Optional rounded output RoundProd is enabled by defining FRACTION_MULT_ROUND_EN.
module fraction_multiplier_param
  import fraction_mult_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           St,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  output logic [2*N-2:0] Product,
  output logic           Done,
  output logic           Busy,
  output logic           Ovf
`ifdef FRACTION_MULT_ROUND_EN
  ,
  output logic [N-1:0]   RoundProd
`endif
);

  localparam int unsigned CntW    = cnt_w(N);
  localparam int unsigned PW      = 2 * N - 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
  localparam logic [PW-1:0]   SatProd = PW'(sat_pos(PW));

  state_e          r_state, w_state_nxt;
  logic [N:0]      r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_m;
  logic [CntW-1:0] r_cnt;
  logic [PW-1:0]   r_product;
  logic            r_ovf;

  logic            w_last;
  logic [N:0]      w_msext;
  logic [N:0]      w_sum;
  logic [N:0]      w_a_nxt;
  logic [N-1:0]    w_b_nxt;
  logic            w_ovf_mul;
  logic [PW-1:0]   w_prod_nxt;
  logic            w_ovf_nxt;

  assign w_last  = (r_cnt == CntLast);
  assign w_msext = {r_m[N-1], r_m};

  // The multiplier sign bit carries weight -1, so the final step subtracts.
  always_comb begin
    w_sum = r_a;
    if (r_b[0]) begin
      w_sum = w_last ? (r_a - w_msext) : (r_a + w_msext);
    end
  end

  assign w_a_nxt = {w_sum[N], w_sum[N:1]};
  assign w_b_nxt = {w_sum[0], r_b[N-1:1]};

  // Only -1 x -1 reaches +1.0, visible as the two top sign bits disagreeing.
  assign w_ovf_mul  = w_a_nxt[N-1] ^ w_a_nxt[N-2];
  assign w_prod_nxt = w_ovf_mul ? SatProd : {w_a_nxt[N-2:0], w_b_nxt};

`ifdef FRACTION_MULT_ROUND_EN
  logic [N-1:0] w_round;
  logic         w_ovf_rnd;
  logic [N-1:0] r_round;

  fraction_mult_round #(
    .N (N)
  ) u_round (
    .i_product (w_prod_nxt),
    .o_round   (w_round),
    .o_ovf_rnd (w_ovf_rnd)
  );

  assign w_ovf_nxt = w_ovf_mul | w_ovf_rnd;
  assign RoundProd = r_round;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_round <= '0;
    end else if (r_state == StCalc && w_last) begin
      r_round <= w_round;
    end
  end
`else
  assign w_ovf_nxt = w_ovf_mul;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (St) w_state_nxt = StCalc;
      StCalc:  if (w_last) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Product/Ovf are written on the last CALC edge so they are valid for the whole DONE cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (St) begin
            r_m   <= Mcand;
            r_b   <= Mplier;
            r_a   <= '0;
            r_cnt <= '0;
          end
        end
        StCalc: begin
          r_a   <= w_a_nxt;
          r_b   <= w_b_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_product <= w_prod_nxt;
            r_ovf     <= w_ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign Product = r_product;
  assign Ovf     = r_ovf;
  assign Done    = (r_state == StDone);
  assign Busy    = (r_state != StIdle);

endmodule

// File: tb/tb_fraction_multiplier_param.sv
// Scoreboard bench: directed N=4 cases plus 1000 back-to-back random N=8 operations.
// Round output is checked when FRACTION_MULT_ROUND_EN is defined.
module tb_fraction_multiplier_param;

  localparam int unsigned NS      = 4;
  localparam int unsigned NL      = 8;
  localparam int unsigned NumRand = 1000;

  typedef struct packed {
    logic [14:0] prod;
    logic        ovf;
    logic [7:0]  rnd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic            st4 = 1'b0;
  logic [NS-1:0]   mp4 = '0;
  logic [NS-1:0]   mc4 = '0;
  logic [2*NS-2:0] prod4;
  logic            done4, busy4, ovf4;

  logic            st8 = 1'b0;
  logic [NL-1:0]   mp8 = '0;
  logic [NL-1:0]   mc8 = '0;
  logic [2*NL-2:0] prod8;
  logic            done8, busy8, ovf8;

`ifdef FRACTION_MULT_ROUND_EN
  logic [NS-1:0] rnd4;
  logic [NL-1:0] rnd8;
`endif

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;

  int n_vec      = 0;
  int n_miss     = 0;
  int cyc        = 0;
  int last_done8 = -1;
  bit spacing_en = 1'b0;

  logic [2*NS-2:0] last_prod4 = '0;
  logic            last_ovf4  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fraction_multiplier_param #(
    .N (NS)
  ) u_dut4 (
    .CLK     (clk),
    .RST_N   (rst_n),
    .St      (st4),
    .Mplier  (mp4),
    .Mcand   (mc4),
    .Product (prod4),
    .Done    (done4),
    .Busy    (busy4),
    .Ovf     (ovf4)
`ifdef FRACTION_MULT_ROUND_EN
    ,
    .RoundProd (rnd4)
`endif
  );

  fraction_multiplier_param #(
    .N (NL)
  ) u_dut8 (
    .CLK     (clk),
    .RST_N   (rst_n),
    .St      (st8),
    .Mplier  (mp8),
    .Mcand   (mc8),
    .Product (prod8),
    .Done    (done8),
    .Busy    (busy8),
    .Ovf     (ovf8)
`ifdef FRACTION_MULT_ROUND_EN
    ,
    .RoundProd (rnd8)
`endif
  );

  // Reference: integer product of the signed operands, scaled implicitly by 2^-(2n-2).
  function automatic exp_t ref_mul(input int unsigned n, input int unsigned a_raw,
                                   input int unsigned b_raw);
    exp_t e;
    int a, b, p, t, maxr;
    a = (a_raw >= (32'd1 << (n - 1))) ? int'(a_raw) - (1 << n) : int'(a_raw);
    b = (b_raw >= (32'd1 << (n - 1))) ? int'(b_raw) - (1 << n) : int'(b_raw);
    e = '0;
    if (a == -(1 << (n - 1)) && b == a) begin
      p     = (1 << (2 * n - 2)) - 1;
      e.ovf = 1'b1;
    end else begin
      p = a * b;
    end
    e.prod = 15'(p & ((1 << (2 * n - 1)) - 1));
    maxr   = (1 << (n - 1)) - 1;
    t      = (p >>> (n - 1)) + ((p >>> (n - 2)) & 1);
    if (t > maxr) begin
      t = maxr;
`ifdef FRACTION_MULT_ROUND_EN
      e.ovf = 1'b1;
`endif
    end
    e.rnd = 8'(t & ((1 << n) - 1));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL done4_unexpected: got Done=1 at cycle %0d, want no pending operation", cyc);
      end else begin
        e4 = q4.pop_front();
        check("prod4", 32'(prod4), 32'(e4.prod));
        check("ovf4", 32'(ovf4), 32'(e4.ovf));
`ifdef FRACTION_MULT_ROUND_EN
        check("rnd4", 32'(rnd4), 32'(e4.rnd[NS-1:0]));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL done8_unexpected: got Done=1 at cycle %0d, want no pending operation", cyc);
      end else begin
        e8 = q8.pop_front();
        check("prod8", 32'(prod8), 32'(e8.prod));
        check("ovf8", 32'(ovf8), 32'(e8.ovf));
`ifdef FRACTION_MULT_ROUND_EN
        check("rnd8", 32'(rnd8), 32'(e8.rnd));
`endif
      end
      if (spacing_en && last_done8 >= 0) begin
        check("spacing8", 32'(cyc - last_done8), 32'(NL + 2));
      end
      last_done8 = cyc;
    end
  end

  // One N=4 operation: checks hold-at-load, Busy, latency; St pulsed mid-CALC must be ignored.
  task automatic run4(input logic [NS-1:0] a, input logic [NS-1:0] b);
    exp_t e;
    int waited;
    e = ref_mul(NS, 32'(a), 32'(b));
    @(negedge clk);
    mp4 = a;
    mc4 = b;
    st4 = 1'b1;
    q4.push_back(e);
    @(posedge clk);
    #1;
    st4 = 1'b0;
    mp4 = NS'($urandom);
    mc4 = NS'($urandom);
    check("busy4_at_load", 32'(busy4), 32'd1);
    check("prod4_hold", 32'(prod4), 32'(last_prod4));
    check("ovf4_hold", 32'(ovf4), 32'(last_ovf4));
    waited = 0;
    while (!done4 && waited < 4 * NS) begin
      @(posedge clk);
      #1;
      waited++;
      st4 = (waited == 1);
      mp4 = NS'($urandom);
      mc4 = NS'($urandom);
    end
    st4 = 1'b0;
    check("latency4", 32'(waited), 32'(NS));
    last_prod4 = e.prod[2*NS-2:0];
    last_ovf4  = e.ovf;
    @(posedge clk);
    #1;
    check("busy4_after_done", 32'(busy4), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int loads, guard, waited;
    logic [NL-1:0] a, b;

    #2 rst_n = 1'b0;
    #1;
    check("rst_prod4", 32'(prod4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_ovf4", 32'(ovf4), 32'd0);
    check("rst_prod8", 32'(prod8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run4(4'b0100, 4'b0100);
    run4(4'b1100, 4'b0100);
    run4(4'b0111, 4'b1001);
    run4(4'b0111, 4'b0111);
    run4(4'b1000, 4'b0111);
    run4(4'b1000, 4'b1000);

    // Abort mid-operation: outputs clear immediately and no Done follows.
    @(negedge clk);
    mp4 = 4'b0100;
    mc4 = 4'b0100;
    st4 = 1'b1;
    @(posedge clk);
    #1;
    st4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_prod4", 32'(prod4), 32'd0);
    check("abort_ovf4", 32'(ovf4), 32'd0);
    check("abort_busy4", 32'(busy4), 32'd0);
    check("abort_done4", 32'(done4), 32'd0);
`ifdef FRACTION_MULT_ROUND_EN
    check("abort_rnd4", 32'(rnd4), 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_prod4 = '0;
    last_ovf4  = 1'b0;
    repeat (NS + 3) @(negedge clk);
    run4(4'b0100, 4'b0100);

    // N=8 back-to-back with St held high; operands presented whenever the DUT is idle.
    spacing_en = 1'b1;
    st8 = 1'b1;
    loads = 0;
    guard = 0;
    while (loads < NumRand && guard < NumRand * (NL + 4)) begin
      @(negedge clk);
      guard++;
      if (!busy8) begin
        if (loads == 0) begin
          a = 8'h80; b = 8'h80;
        end else if (loads == 1) begin
          a = 8'h7F; b = 8'h7F;
        end else if (loads == 2) begin
          a = 8'h80; b = 8'h7F;
        end else begin
          a = NL'($urandom);
          b = NL'($urandom);
        end
        mp8 = a;
        mc8 = b;
        q8.push_back(ref_mul(NL, 32'(a), 32'(b)));
        loads++;
      end else begin
        mp8 = NL'($urandom);
        mc8 = NL'($urandom);
      end
    end
    @(posedge clk);
    #1;
    st8 = 1'b0;
    if (loads < NumRand) begin
      n_vec++;
      n_miss++;
      $display("FAIL loads8_timeout: got %0d loads, want %0d", loads, NumRand);
    end
    waited = 0;
    while ((q8.size() != 0 || q4.size() != 0) && waited < 4 * NL) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    spacing_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
